// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// valid/ready handshake on both operand input and result output.
module seq_restoring_divider #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q,     state_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] rem_q,       rem_d;
   logic [WIDTH-1:0] quo_q,       quo_d;
   logic [WIDTH-1:0] dreg_q,      dreg_d;
   logic [WIDTH-1:0] quotient_q,  quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q,       dbz_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;

   // Partial remainder shifted left by one with the next dividend bit, and
   // the WIDTH+1-bit trial subtraction whose MSB is the borrow.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;

   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dreg_q};
   assign borrow  = trial[WIDTH];

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dreg_d      = dreg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               quo_d  = dividend;
               dreg_d = divisor;
               rem_d  = '0;
               cnt_d  = CW'(WIDTH - 1);
               if (divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~borrow};
            if (cnt_q == '0) begin
               state_d     = S_DONE;
               quotient_d  = quo_d;
               remainder_d = rem_d;
               dbz_d       = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dreg_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dreg_q      <= dreg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks for seq_restoring_divider at WIDTH=6.
module tb_seq_restoring_divider;

   localparam int unsigned W = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int unsigned  n_cmp = 0;
   int unsigned  n_mis = 0;
   int unsigned  n_hs  = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Output handshakes actually seen on the bus
   always @(posedge clk) begin
      if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) n_hs <= n_hs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d", tag, got, got, exp);
      end
   endtask

   // Present operands in IDLE and return after the accept edge (+1).
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned t;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) chk("in_ready_timeout", 32'(t), 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is seen.
   task automatic wait_valid(output int unsigned lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned eq, input int unsigned er, input int unsigned ez,
                         input int unsigned elat);
      int unsigned lat;
      out_ready = 1'b1;
      accept(a, b);
      wait_valid(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_quo"}, 32'(quotient), 32'(eq));
      chk({tag, "_rem"}, 32'(remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
      @(posedge clk);
      #1;
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
      chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int unsigned lat;
      int unsigned hs0;
      logic        saw_valid;
      logic [W-1:0] eq, er;
      logic        ez;

      // Asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("d45_7", 6'd45, 6'd7, 6, 3, 0, W);
      run_op("d63_1", 6'd63, 6'd1, 63, 0, 0, W);
      run_op("d5_9", 6'd5, 6'd9, 0, 5, 0, W);
      run_op("d0_5", 6'd0, 6'd5, 0, 0, 0, W);
      run_op("d20_0", 6'd20, 6'd0, 63, 20, 1, 0);
      run_op("d12_4", 6'd12, 6'd4, 3, 0, 0, W);

      // Backpressure: result held while consumer stalls
      out_ready = 1'b0;
      accept(6'd50, 6'd6);
      wait_valid(lat);
      chk("bp_lat", 32'(lat), 32'(W));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_quo", 32'(quotient), 32'd8);
         chk("bp_rem", 32'(remainder), 32'd2);
         chk("bp_rdy", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_rel_rdy", 32'(in_ready), 32'd1);
      chk("bp_rel_vld", 32'(out_valid), 32'd0);

      // Operand changes during CALC are ignored
      accept(6'd45, 6'd7);
      dividend = 6'd3;
      divisor  = 6'd0;
      wait_valid(lat);
      chk("iso_quo", 32'(quotient), 32'd6);
      chk("iso_rem", 32'(remainder), 32'd3);
      chk("iso_dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk);

      // Reset during CALC step 3 discards the operation
      accept(6'd45, 6'd7);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mrst_rdy", 32'(in_ready), 32'd1);
      chk("mrst_vld", 32'(out_valid), 32'd0);
      chk("mrst_quo", 32'(quotient), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1 if (out_valid !== 1'b0) saw_valid = 1'b1;
      end
      chk("mrst_no_valid", 32'(saw_valid), 32'd0);
      run_op("d33_4", 6'd33, 6'd4, 8, 1, 0, W);

      // Exhaustive back-to-back with random consumer stalls
      hs0 = n_hs;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            eq = (b == 0) ? 6'd63 : W'(a / b);
            er = (b == 0) ? W'(a) : W'(a % b);
            ez = (b == 0);
            out_ready = 1'($urandom_range(1));
            accept(W'(a), W'(b));
            lat = 0;
            while (!(out_valid === 1'b1 && out_ready === 1'b1) && lat < 200) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(1));
               lat++;
            end
            chk("ex_quo", 32'(quotient), 32'(eq));
            chk("ex_rem", 32'(remainder), 32'(er));
            chk("ex_dbz", 32'(div_by_zero), 32'(ez));
            @(posedge clk);
            #1;
         end
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ex_handshakes", 32'(n_hs - hs0), 32'd4096);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
